dcache_dm: RTL and testbench
============================

Name: dcache_dm

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the memory-stage datapath and the backing data memory.
- Read hits return data combinationally in the same cycle.
- Read misses refill a full line through a per-beat req/ack handshake; every store goes through to memory.
- `stall` freezes the pipeline while any memory transaction is outstanding.

Parameters:
- WIDTH, 32, data and address width.
- SETS, 64, number of lines (power of two).
- WORDS_PER_LINE, 4, words per line (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cpu_rd_en  in  1  load request
- cpu_wr_en  in  1  store request
- cpu_addr  in  WIDTH  byte address
- cpu_wdata  in  WIDTH  store data, already lane-aligned
- cpu_be  in  4  store byte enables
- cpu_rdata  out  WIDTH  load word
- stall  out  1  freeze pipeline; cpu_* held stable while high
- mem_req  out  1  beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  WIDTH  word-aligned beat address
- mem_wdata  out  WIDTH  write data
- mem_be  out  4  write byte enables
- mem_ack  in  1  beat complete (read data valid on mem_rdata)
- mem_rdata  in  WIDTH  read beat data

Behaviour:
- Address split: offset [1:0] ignored; word = next log2(WORDS_PER_LINE) bits; index = next log2(SETS) bits; tag = remainder.
- Storage: valid bit and tag per line, data array per word. Valid bits are flops cleared by reset; data and tag are not reset.
- Reset (rst=0, async):
  - state=IDLE, all valid=0, beat counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - stall=0, cpu_rdata=0.
- States: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit (valid & tag match, rd_en=1, wr_en=0): cpu_rdata = stored word, stall=0, no memory traffic.
  - Read miss: stall=1 combinationally in the same cycle. Next state REFILL, beat=0, line's valid cleared.
  - Write (wr_en=1, regardless of rd_en; write has priority): stall=1 in the same cycle. Next state WRITE.
    - On a hit, the cache word is updated per cpu_be at that clock edge.
    - On a miss, the cache is unchanged.
  - No request: stall=0, cpu_rdata=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = line base + 4*beat.
  - Request and address are held until mem_ack.
  - On mem_ack: store mem_rdata at word[beat], beat++.
  - On the ack of beat WORDS_PER_LINE-1: write tag, set valid, go IDLE.
  - In the following IDLE cycle the access hits, returns data and drops stall.
  - Minimum miss penalty is WORDS_PER_LINE+1 cycles with mem_ack asserted continuously.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr = cpu_addr with [1:0]=0, mem_wdata=cpu_wdata, mem_be=cpu_be.
  - Hold until mem_ack, then go IDLE with stall=0 that cycle.
  - The write completes exactly once; the pipeline advances on the cycle stall is low.
- Stall timing in WRITE: stall remains 1 in WRITE until the cycle after the ack.
- mem_ack outside REFILL/WRITE: ignored.
- Reset mid-refill: line stays invalid, partial data discarded, memory request dropped immediately.
- Back-to-back same-line misses: the second access is a hit after the refill.
- A conflicting index simply replaces the line; no writeback is needed because the cache is write-through.

Optional Feature:
- DCACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count, each 32 bits, reset to 0.
  - hit_count increments once per IDLE read hit that completes. Hits following a refill count as misses only, not hits.
  - miss_count increments once per transition into REFILL.
  - Counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then read 0x0000_0100 with memory returning 0x11,0x22,0x33,0x44 on four consecutive acks:
  - stall high for 5 cycles, cpu_rdata=0x11.
  - Then reading 0x104 returns 0x22 with stall=0 and no mem_req.
- Store 0xAABBCCDD, be=0b0011 to cached 0x108 (prior 0x33):
  - one write beat on mem_be=0011.
  - Subsequent read 0x108 hits with 0x0000CCDD.
- Store to uncached 0x2000:
  - write beat issued, valid unchanged.
  - Subsequent read of 0x2000 triggers REFILL.
- Conflict: read 0x100, then 0x100 + SETS*16 (same index, different tag):
  - second access refills.
  - Returning to 0x100 misses again.
- mem_ack delayed 3 cycles per beat:
  - mem_addr and mem_req stable throughout each beat.
  - stall high for 17 cycles on a read miss.
- Assert rst low during beat 2 of a refill:
  - mem_req=0 immediately.
  - After release, the same read misses again and performs a full 4-beat refill.

Source files
------------

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with a per-beat req/ack refill port.
// Define DCACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module dcache_dm #(
    parameter int WIDTH          = 32,
    parameter int SETS           = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_rd_en,
    input  logic             cpu_wr_en,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    input  logic [3:0]       cpu_be,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WIDTH - 2 - OFF_W - IDX_W;
    localparam int LAST_BEAT = WORDS_PER_LINE - 1;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    state_t state;
    state_t next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_arr  [SETS];
    logic [WIDTH-1:0] data_arr [SETS*WORDS_PER_LINE];

    logic [OFF_W-1:0] beat;
    logic             resume;
    logic             stall_raw;

    logic [OFF_W-1:0]       word_sel;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             unused_offset;
    logic                   hit;
    logic [IDX_W+OFF_W-1:0] rd_slot;
    logic [IDX_W+OFF_W-1:0] fill_slot;
    logic                   fill_ack;
    logic                   fill_last;
    logic                   write_hit;
    logic                   start_refill;

    assign word_sel      = cpu_addr[2 +: OFF_W];
    assign index         = cpu_addr[2+OFF_W +: IDX_W];
    assign tag           = cpu_addr[WIDTH-1 -: TAG_W];
    assign unused_offset = cpu_addr[1:0];
    assign hit           = valid[index] && (tag_arr[index] == tag);
    assign rd_slot       = {index, word_sel};
    assign fill_slot     = {index, beat};

    assign fill_ack     = (state == REFILL) && mem_ack;
    assign fill_last    = fill_ack && (beat == OFF_W'(LAST_BEAT));
    assign write_hit    = (state == IDLE) && !resume && cpu_wr_en && hit;
    assign start_refill = (state == IDLE) && (next_state == REFILL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // resume marks the single IDLE cycle in which a just-finished transaction is handed back
    // to the pipeline, so the still-held request is not issued a second time.
    always_comb begin
        next_state = state;
        stall_raw  = 1'b0;
        cpu_rdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        case (state)
            IDLE: begin
                if (cpu_rd_en && !cpu_wr_en && hit) begin
                    cpu_rdata = data_arr[rd_slot];
                end
                if (!resume) begin
                    if (cpu_wr_en) begin
                        stall_raw  = 1'b1;
                        next_state = WRITE;
                    end else if (cpu_rd_en && !hit) begin
                        stall_raw  = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                stall_raw = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {cpu_addr[WIDTH-1:2+OFF_W], beat, 2'b00};
                if (mem_ack && (beat == OFF_W'(LAST_BEAT))) begin
                    next_state = IDLE;
                end
            end
            WRITE: begin
                stall_raw = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {cpu_addr[WIDTH-1:2], 2'b00};
                mem_wdata = cpu_wdata;
                mem_be    = cpu_be;
                if (mem_ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A held load must not raise stall while the cache is being reset.
    assign stall = stall_raw && rst;

    // The line is invalidated as soon as its refill starts, so an aborted refill leaves it empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= '0;
            beat   <= '0;
            resume <= 1'b0;
        end else begin
            resume <= (state != IDLE) && (next_state == IDLE);
            if (start_refill) begin
                valid[index] <= 1'b0;
                beat         <= '0;
            end
            if (fill_ack) begin
                beat <= beat + OFF_W'(1);
                if (fill_last) begin
                    valid[index] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_ack) begin
            data_arr[fill_slot] <= mem_rdata;
            if (fill_last) begin
                tag_arr[index] <= tag;
            end
        end else if (write_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_be[b]) begin
                    data_arr[rd_slot][8*b +: 8] <= cpu_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic read_hit_done;

    // Hits served in the resume cycle after a refill were already counted as misses.
    assign read_hit_done = (state == IDLE) && !resume && cpu_rd_en && !cpu_wr_en && hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (read_hit_done) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_refill) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Scoreboard bench for dcache_dm: a driver queues expected responses, a monitor checks them
// against what the cache returns, while a small memory model answers beats with a set ack delay.
module tb_dcache_dm;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             cpu_rd_en;
    logic             cpu_wr_en;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic [3:0]       cpu_be;
    logic [WIDTH-1:0] cpu_rdata;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]      hit_count;
    logic [31:0]      miss_count;
`endif

    dcache_dm #(
        .WIDTH(32),
        .SETS(64),
        .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_rd_en(cpu_rd_en),
        .cpu_wr_en(cpu_wr_en),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata),
        .stall(stall),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_be(mem_be),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    typedef struct {
        int          id;
        logic        is_read;
        logic [31:0] rdata;
        int          stall_cyc;
        int          rbeats;
        int          wbeats;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    int          access_id  = 0;
    int          ack_delay  = 0;
    int          resp_cnt   = 0;
    int          mon_stall  = 0;
    int          mon_rbeats = 0;
    int          mon_wbeats = 0;
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] mem_wr [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory: the first line at 0x100 holds 0x11..0x44, everything else reads 0xD000_0000|addr.
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        case (a)
            32'h100: return 32'h11;
            32'h104: return 32'h22;
            32'h108: return 32'h33;
            32'h10C: return 32'h44;
            default: return 32'hD000_0000 | a;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Memory responder: acks a beat after ack_delay idle request cycles.
    initial begin
        logic [31:0] merged;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (resp_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_read(mem_addr);
                    if (mem_we) begin
                        merged = mem_read(mem_addr);
                        for (int b = 0; b < 4; b++) begin
                            if (mem_be[b]) merged[8*b +: 8] = mem_wdata[8*b +: 8];
                        end
                        mem_wr[mem_addr] = merged;
                    end
                    resp_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    resp_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                resp_cnt = 0;
            end
        end
    end

    // Monitor: tallies stall cycles and beats per access and scores the access when stall drops.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                mon_stall  = 0;
                mon_rbeats = 0;
                mon_wbeats = 0;
                prev_req   = 1'b0;
                prev_ack   = 1'b0;
                exp_q.delete();
            end else begin
                if (prev_req && !prev_ack) begin
                    checkOutput("req_held", {31'b0, mem_req}, 32'd1);
                    checkOutput("addr_held", mem_addr, prev_addr);
                end
                prev_req  = mem_req;
                prev_ack  = mem_ack;
                prev_addr = mem_addr;
                if (cpu_rd_en || cpu_wr_en) begin
                    if (mem_req && mem_ack) begin
                        if (mem_we) begin
                            mon_wbeats++;
                            checkOutput("write_beat_expected", 32'(exp_q.size() != 0), 32'd1);
                            if (exp_q.size() != 0) begin
                                checkOutput($sformatf("%0d.mem_addr", exp_q[0].id), mem_addr, exp_q[0].waddr);
                                checkOutput($sformatf("%0d.mem_wdata", exp_q[0].id), mem_wdata, exp_q[0].wdata);
                                checkOutput($sformatf("%0d.mem_be", exp_q[0].id), {28'b0, mem_be}, {28'b0, exp_q[0].wbe});
                            end
                        end else begin
                            mon_rbeats++;
                        end
                    end
                    if (stall) begin
                        mon_stall++;
                    end else begin
                        checkOutput("completion_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            mon_e = exp_q.pop_front();
                            if (mon_e.is_read) begin
                                checkOutput($sformatf("%0d.cpu_rdata", mon_e.id), cpu_rdata, mon_e.rdata);
                            end
                            checkOutput($sformatf("%0d.stall_cycles", mon_e.id), 32'(mon_stall), 32'(mon_e.stall_cyc));
                            checkOutput($sformatf("%0d.read_beats", mon_e.id), 32'(mon_rbeats), 32'(mon_e.rbeats));
                            checkOutput($sformatf("%0d.write_beats", mon_e.id), 32'(mon_wbeats), 32'(mon_e.wbeats));
                        end
                        mon_stall  = 0;
                        mon_rbeats = 0;
                        mon_wbeats = 0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input logic [31:0] exp_rdata, input int exp_stall,
                                 input int exp_rb, input int exp_wb);
        exp_t e;
        bit   done;
        access_id++;
        e.id        = access_id;
        e.is_read   = rd && !wr;
        e.rdata     = exp_rdata;
        e.stall_cyc = exp_stall;
        e.rbeats    = exp_rb;
        e.wbeats    = exp_wb;
        e.waddr     = {addr[31:2], 2'b00};
        e.wdata     = wdata;
        e.wbe       = be;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cpu_rd_en = rd;
        cpu_wr_en = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        done      = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) checkOutput($sformatf("%0d.stall_timeout", e.id), {31'b0, stall}, 32'd0);
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
    endtask

    task automatic resetDuringRefill(input logic [31:0] addr);
        bit found;
        ack_delay = 3;
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b1;
        cpu_addr  = addr;
        found     = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (mem_req && (mem_addr == addr + 32'h8)) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("beat2_reached", {31'b0, found}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        cpu_rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        ack_delay = 0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        cpu_rd_en = 1'b1;
        cpu_wr_en = 1'b0;
        cpu_addr  = 32'h100;
        cpu_wdata = '0;
        cpu_be    = '0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
        cpu_rd_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        //             rd    wr    addr          wdata          be       rdata          stall rb wb
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'h0000_0011, 5,    4, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 32'h0000_0022, 0,    0, 0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0108, 32'hAABB_CCDD, 4'b0011, 32'h0,         2,    0, 1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0108, 32'h0,         4'b0000, 32'h0000_CCDD, 0,    0, 0);
        applyStimulus(1'b0, 1'b1, 32'h0000_2002, 32'h1234_5678, 4'b1111, 32'h0,         2,    0, 1);
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0,         4'b0000, 32'h1234_5678, 5,    4, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0,         4'b0000, 32'hD000_0500, 5,    4, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'h0000_0011, 5,    4, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_010C, 32'h0,         4'b0000, 32'h0000_0044, 0,    0, 0);

        ack_delay = 3;
        applyStimulus(1'b1, 1'b0, 32'h0000_0700, 32'h0,         4'b0000, 32'hD000_0700, 17,   4, 0);
        ack_delay = 0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0704, 32'h0,         4'b0000, 32'hD000_0704, 0,    0, 0);

        resetDuringRefill(32'h0000_0A00);
        applyStimulus(1'b1, 1'b0, 32'h0000_0A00, 32'h0,         4'b0000, 32'hD000_0A00, 5,    4, 0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 32'h0000_0022, 5,    4, 0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0104, 32'hFFFF_FFFF, 4'b1000, 32'h0,         2,    0, 1);
        applyStimulus(1'b1, 1'b0, 32'h0000_0104, 32'h0,         4'b0000, 32'hFF00_0022, 0,    0, 0);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
